// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: one outstanding word request to instruction memory,
// unpacks each word into 32-bit instructions and queues them (with PC) for decode.
module fetch_buffer #(
  parameter int          ADDR_WIDTH  = 4,
  parameter int          FETCH_BYTES = 8,
  parameter int          QDEPTH      = 4,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [FETCH_BYTES*8-1:0] mem_resp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [63:0]              instr_pc
);
  localparam int OFS = $clog2(FETCH_BYTES);
  localparam int IPW = FETCH_BYTES / 4;
  localparam int QW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [QW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     q_instr [QDEPTH];
  logic [63:0]     q_pc    [QDEPTH];

  logic [63:0]     word_base;
  logic [31:0]     slot;
  logic            push, pop;
  logic [CW-1:0]   push_n;
  logic [IPW-1:0]  wr_en;
  logic [QW-1:0]   wr_idx [IPW];

  assign word_base = fetch_pc_q & ~64'(FETCH_BYTES - 1);
  assign slot      = 32'(fetch_pc_q[OFS-1:0]) >> 2;
  assign push      = (state_q == WAIT) && mem_resp_valid && !redirect_valid;
  assign pop       = instr_valid && instr_ready;
  assign push_n    = CW'(IPW - int'(slot));

  // Slots below the entry slot (branch target mid-word) are skipped; the rest pack from tail.
  always_comb begin
    for (int k = 0; k < IPW; k++) begin
      wr_en[k]  = push && (k >= int'(slot));
      wr_idx[k] = tail_q + QW'(k - int'(slot));
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q - CW'(pop) + (push ? push_n : '0);
    unique case (state_q)
      IDLE: if (count_q <= CW'(QDEPTH - IPW)) state_d = REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) begin
        state_d    = IDLE;
        fetch_pc_d = word_base + 64'(FETCH_BYTES);
      end
      DROP: if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A request already accepted by memory must have its response swallowed in DROP.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~64'h3;
      count_d    = '0;
      unique case (state_q)
        REQ:        state_d = mem_req_ready  ? DROP : IDLE;
        WAIT, DROP: state_d = mem_resp_valid ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (pop)  head_q <= head_q + QW'(1);
        if (push) tail_q <= tail_q + QW'(push_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < IPW; k++) begin
      if (wr_en[k]) begin
        q_instr[wr_idx[k]] <= mem_resp_data[32*k +: 32];
        q_pc[wr_idx[k]]    <= word_base + 64'(4 * k);
      end
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = fetch_pc_q[ADDR_WIDTH+OFS-1:OFS];
  assign instr_valid   = (count_q != '0);
  assign instr         = q_instr[head_q];
  assign instr_pc      = q_pc[head_q];
endmodule
